pw_ranger: RTL and testbench
============================

// Module: pw_ranger
// PURPOSE
//  Multi-channel pulse-width rangefinder front end for ultrasonic PW-output sensors (147 us/inch).
//  Synchronises each PW input and measures each high pulse in distance units (e.g. cm) using a prescaler.
//  Applies a timeout and keeps a power-of-two moving average per channel.
//  Sits between the sensor pins and the level/display logic; one instance serves all sensors.
// PARAMETERS
//  N_CH          2      number of independent PW channels
//  CLK_PER_UNIT  2894   clk cycles per distance unit (50 MHz, cm: 147us/2.54 = 57.87us)
//  DIST_W        16     width of distance / average values
//  TIMEOUT_UNITS 650    pulse still high at this unit count -> timeout
//  AVG_LOG2      3      log2 of moving-average depth (default 8 samples)
// PORTS
//  clk         in   1             system clock; all logic on posedge clk
//  reset       in   1             synchronous, active-high reset
//  pw          in   N_CH          raw asynchronous PW pins, bit i = channel i
//  distance    out  N_CH*DIST_W   last valid measurement, channel i at [i*DIST_W +: DIST_W]
//  meas_valid  out  N_CH          1-cycle strobe: distance[i] just updated
//  dist_avg    out  N_CH*DIST_W   moving average of last 2**AVG_LOG2 measurements
//  avg_valid   out  N_CH          1-cycle strobe: dist_avg[i] just updated
//  avg_ready   out  N_CH          high once channel buffer has been filled since reset
//  timeout     out  N_CH          1-cycle strobe: pulse exceeded TIMEOUT_UNITS
// BEHAVIOUR
//  - Reset: all outputs 0. Ring buffer, running sum, fill count, prescaler and unit counter are 0.
//    FSM goes to WAIT_LOW. Reset mid-pulse discards that pulse.
//  - Sync: pw -> ff1 -> ff2. prev <= ff2. rise = ff2 & ~prev; fall = ~ff2 & prev.
//  - FSM per channel:
//      WAIT_LOW -> IDLE     when ff2 == 0.
//      IDLE     -> MEASURE  on rise; prescaler and unit counter cleared.
//      MEASURE:
//        prescaler counts 0..CLK_PER_UNIT-1.
//        On wrap, the unit counter increments.
//        On fall -> IDLE: distance <= unit count; meas_valid = 1.
//        When the unit count reaches TIMEOUT_UNITS with ff2 still high -> WAIT_LOW: timeout = 1.
//          No sample is taken. distance and the average are unchanged.
//  - Result: P cycles of ff2 high -> distance = floor(P/CLK_PER_UNIT). P < CLK_PER_UNIT gives 0 (still valid).
//  - Latency: distance/meas_valid update on the 3rd posedge, counting the one that first samples pw low.
//  - Average:
//      Cycle after meas_valid: sum <= sum + new - oldest. oldest is overwritten in the ring. The write pointer wraps mod 2**AVG_LOG2.
//      sum width = DIST_W + AVG_LOG2, no overflow.
//      dist_avg = sum >> AVG_LOG2 (truncating).
//      avg_valid pulses on every update after the buffer is full. The first pulse comes with the 2**AVG_LOG2-th sample.
//      Until then dist_avg stays 0 and avg_ready stays 0.
//  - Channels are fully independent. Simultaneous edges on several channels are all handled in the same cycle.
//  - A rise seen in WAIT_LOW is ignored. A pulse seen in IDLE with no preceding low is not measured.
// STRUCTURE
//  - pw_ranger_pkg: state enum typedef (WAIT_LOW, IDLE, MEASURE), default constants.
//  - Sub-module pw_ranger_ch: one channel (sync, FSM, prescaler, ring buffer, sum).
//    Instantiated N_CH times in a generate loop; the top only slices buses.
// TESTING (CLK_PER_UNIT=10, TIMEOUT_UNITS=20, AVG_LOG2=2, N_CH=2)
//  1. ch0 pw high 57 cycles -> distance=5, meas_valid one cycle at the specified latency; no timeout.
//  2. ch0 pulses 40,80,120,160 cycles ->
//       distances 4,8,12,16; avg_valid/avg_ready first after the 4th sample, dist_avg=10.
//     Next pulse 200 cycles -> distance=20, dist_avg=14.
//  3. ch0 pulse 250 cycles -> timeout strobe after 200 high cycles; no meas_valid; distance unchanged.
//     Next 30-cycle pulse measures 3.
//  4. reset asserted mid-pulse, released with pw high ->
//       no measurement for that pulse, outputs 0; the following 70-cycle pulse gives 7.
//  5. ch0 90 and ch1 30 cycles with the same falling edge ->
//       both meas_valid in the same cycle, distances 9 and 3.
//  6. ch0 pulse of 5 cycles -> distance=0 with meas_valid; pw glitch of 1 cycle also yields 0, no hang.

Source files
------------

// File: rtl/pw_ranger_pkg.sv
// Shared types and default constants for the pulse-width rangefinder.
package pw_ranger_pkg;

  // Per-channel measurement state.
  typedef enum logic [1:0] {
    ST_WAIT_LOW = 2'd0,  // wait for a clean low before arming
    ST_IDLE     = 2'd1,  // armed, waiting for a rising edge
    ST_MEASURE  = 2'd2   // pulse in progress, counting units
  } state_e;

  // Defaults: 50 MHz clock, centimetre units (147 us/inch / 2.54).
  localparam int unsigned DEF_N_CH          = 2;
  localparam int unsigned DEF_CLK_PER_UNIT  = 2894;
  localparam int unsigned DEF_DIST_W        = 16;
  localparam int unsigned DEF_TIMEOUT_UNITS = 650;
  localparam int unsigned DEF_AVG_LOG2      = 3;

  // Counter width for a modulus, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned modulus);
    int unsigned w;
    if (modulus > 32'd1) begin
      w = $clog2(modulus);
    end else begin
      w = 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pw_ranger_ch.sv
// One rangefinder channel: input synchroniser, measurement FSM with
// prescaler and unit counter, and the moving-average ring buffer.
module pw_ranger_ch
  import pw_ranger_pkg::*;
#(
  parameter int unsigned CLK_PER_UNIT  = DEF_CLK_PER_UNIT,
  parameter int unsigned DIST_W        = DEF_DIST_W,
  parameter int unsigned TIMEOUT_UNITS = DEF_TIMEOUT_UNITS,
  parameter int unsigned AVG_LOG2      = DEF_AVG_LOG2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              pw_i,
  output logic [DIST_W-1:0] distance_o,
  output logic              meas_valid_o,
  output logic [DIST_W-1:0] dist_avg_o,
  output logic              avg_valid_o,
  output logic              avg_ready_o,
  output logic              timeout_o
);

  localparam int unsigned PS_W  = cnt_width(CLK_PER_UNIT);
  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = DIST_W + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;

  logic ff1_q, ff2_q, prev_q;
  logic rise_s, fall_s;

  state_e            state_q, state_d;
  logic [PS_W-1:0]   presc_q, presc_d;
  logic [DIST_W-1:0] units_q, units_d, units_inc_s;
  logic              presc_wrap_s;
  logic [DIST_W-1:0] distance_q, distance_d;
  logic              meas_valid_q, meas_valid_d;
  logic              timeout_q, timeout_d;

  logic [DIST_W-1:0]   ring_q [DEPTH];
  logic [AVG_LOG2-1:0] wp_q;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [CNT_W-1:0]    fill_q;
  logic [DIST_W-1:0]   dist_avg_q;
  logic                avg_valid_q, avg_ready_q;
  logic                full_now_s;

  // Two-flop synchroniser plus edge history. Preset high so a pulse already
  // in progress when reset releases is not mistaken for a fresh rising edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ff1_q  <= 1'b1;
      ff2_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      ff1_q  <= pw_i;
      ff2_q  <= ff1_q;
      prev_q <= ff2_q;
    end
  end

  assign rise_s       = ff2_q & ~prev_q;
  assign fall_s       = ~ff2_q & prev_q;
  assign presc_wrap_s = (presc_q == PS_W'(CLK_PER_UNIT - 1));
  assign units_inc_s  = presc_wrap_s ? (units_q + DIST_W'(1)) : units_q;

  // Measurement FSM: next state, counters and result strobes.
  // The unit count including the current cycle is captured on the fall, so
  // P synchronised high cycles yield floor(P / CLK_PER_UNIT).
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    units_d      = units_q;
    distance_d   = distance_q;
    meas_valid_d = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      ST_WAIT_LOW: begin
        if (!ff2_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_LOW;
        end
      end
      ST_IDLE: begin
        if (rise_s) begin
          state_d = ST_MEASURE;
          presc_d = '0;
          units_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        if (fall_s) begin
          state_d      = ST_IDLE;
          distance_d   = units_inc_s;
          meas_valid_d = 1'b1;
        end else if (ff2_q && (units_q >= DIST_W'(TIMEOUT_UNITS))) begin
          state_d   = ST_WAIT_LOW;
          timeout_d = 1'b1;
        end else begin
          state_d = ST_MEASURE;
          presc_d = presc_wrap_s ? '0 : (presc_q + PS_W'(1));
          units_d = units_inc_s;
        end
      end
      default: begin
        state_d = ST_WAIT_LOW;
      end
    endcase
  end

  // FSM, counters and registered measurement outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_WAIT_LOW;
      presc_q      <= '0;
      units_q      <= '0;
      distance_q   <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      units_q      <= units_d;
      distance_q   <= distance_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  // Running sum update: add the new sample, drop the one it overwrites.
  // Unfilled slots hold zero, so the sum is exact during the fill phase.
  always_comb begin
    full_now_s = avg_ready_q | (fill_q == CNT_W'(DEPTH - 1));
    if (meas_valid_q) begin
      sum_d = sum_q + SUM_W'(distance_q) - SUM_W'(ring_q[wp_q]);
    end else begin
      sum_d = sum_q;
    end
  end

  // Ring buffer, sum and average outputs, updated the cycle after a sample.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ring_q[i] <= '0;
      end
      wp_q        <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      dist_avg_q  <= '0;
      avg_valid_q <= 1'b0;
      avg_ready_q <= 1'b0;
    end else if (meas_valid_q) begin
      ring_q[wp_q] <= distance_q;
      wp_q         <= wp_q + AVG_LOG2'(1);
      sum_q        <= sum_d;
      if (!avg_ready_q) begin
        fill_q <= fill_q + CNT_W'(1);
      end else begin
        fill_q <= fill_q;
      end
      avg_ready_q <= full_now_s;
      avg_valid_q <= full_now_s;
      if (full_now_s) begin
        dist_avg_q <= sum_d[SUM_W-1 -: DIST_W];
      end else begin
        dist_avg_q <= dist_avg_q;
      end
    end else begin
      avg_valid_q <= 1'b0;
    end
  end

  assign distance_o   = distance_q;
  assign meas_valid_o = meas_valid_q;
  assign timeout_o    = timeout_q;
  assign dist_avg_o   = dist_avg_q;
  assign avg_valid_o  = avg_valid_q;
  assign avg_ready_o  = avg_ready_q;

endmodule

// File: rtl/pw_ranger.sv
// Multi-channel PW rangefinder front end: one independent channel per pin;
// the top only slices the flat output buses.
module pw_ranger
  import pw_ranger_pkg::*;
#(
  parameter int unsigned N_CH          = DEF_N_CH,
  parameter int unsigned CLK_PER_UNIT  = DEF_CLK_PER_UNIT,
  parameter int unsigned DIST_W        = DEF_DIST_W,
  parameter int unsigned TIMEOUT_UNITS = DEF_TIMEOUT_UNITS,
  parameter int unsigned AVG_LOG2      = DEF_AVG_LOG2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [N_CH-1:0]          pw_i,
  output logic [N_CH*DIST_W-1:0]   distance_o,
  output logic [N_CH-1:0]          meas_valid_o,
  output logic [N_CH*DIST_W-1:0]   dist_avg_o,
  output logic [N_CH-1:0]          avg_valid_o,
  output logic [N_CH-1:0]          avg_ready_o,
  output logic [N_CH-1:0]          timeout_o
);

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    pw_ranger_ch #(
      .CLK_PER_UNIT  (CLK_PER_UNIT),
      .DIST_W        (DIST_W),
      .TIMEOUT_UNITS (TIMEOUT_UNITS),
      .AVG_LOG2      (AVG_LOG2)
    ) u_ch (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .pw_i         (pw_i[g]),
      .distance_o   (distance_o[g*DIST_W +: DIST_W]),
      .meas_valid_o (meas_valid_o[g]),
      .dist_avg_o   (dist_avg_o[g*DIST_W +: DIST_W]),
      .avg_valid_o  (avg_valid_o[g]),
      .avg_ready_o  (avg_ready_o[g]),
      .timeout_o    (timeout_o[g])
    );
  end

endmodule

// File: tb/tb_pw_ranger.sv
// Self-checking bench for pw_ranger: directed scenarios plus random pulse
// pairs, checked cycle by cycle against a pulse-level reference model.
module tb_pw_ranger;

  localparam int N_CH  = 2;
  localparam int CPU   = 10;
  localparam int DW    = 16;
  localparam int TO    = 20;
  localparam int AL2   = 2;
  localparam int DEPTH = 1 << AL2;
  localparam int GAP   = 6;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [N_CH-1:0]    pw = '0;
  logic [N_CH*DW-1:0] distance, dist_avg;
  logic [N_CH-1:0]    meas_valid, avg_valid, avg_ready, timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct { int ch; int cyc; int val; } exp_t;
  exp_t meas_q[$];
  exp_t to_q[$];

  int samples [N_CH][256];
  int nsamp   [N_CH];
  int avg_due [N_CH];
  int avg_exp [N_CH];

  pw_ranger #(
    .N_CH(N_CH), .CLK_PER_UNIT(CPU), .DIST_W(DW),
    .TIMEOUT_UNITS(TO), .AVG_LOG2(AL2)
  ) dut (
    .clk_i(clk), .reset_i(reset), .pw_i(pw),
    .distance_o(distance), .meas_valid_o(meas_valid),
    .dist_avg_o(dist_avg), .avg_valid_o(avg_valid),
    .avg_ready_o(avg_ready), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    meas_q.delete();
    to_q.delete();
    for (int i = 0; i < N_CH; i++) begin
      nsamp[i]   = 0;
      avg_due[i] = -1;
      avg_exp[i] = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_model();
    step(3);
    reset = 1'b0;
    step(1);
  endtask

  // Drive pulses of l0/l1 synchronous-clock cycles whose falling edges coincide
  // (0 = no pulse), then a low gap. Expectations derive from pulse length only:
  // distance = len/CPU, or a timeout once the sensor would still be high with
  // TO units already counted.
  task automatic pulse2(input int l0, input int l1);
    int lens[N_CH];
    int mx;
    exp_t e;
    lens[0] = l0;
    lens[1] = l1;
    mx = (l0 > l1) ? l0 : l1;
    for (int k = 0; k < mx; k++) begin
      step(1);
      for (int i = 0; i < N_CH; i++) begin
        if (lens[i] > 0 && k == mx - lens[i]) begin
          pw[i] = 1'b1;
          if (lens[i] >= TO * CPU + 2) begin
            e.ch = i; e.cyc = cyc + TO * CPU + 4; e.val = 0;
            to_q.push_back(e);
          end
        end
      end
    end
    step(1);
    pw = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (lens[i] > 0 && lens[i] < TO * CPU + 2) begin
        e.ch = i; e.cyc = cyc + 3; e.val = lens[i] / CPU;
        meas_q.push_back(e);
      end
    end
    step(GAP);
  endtask

  // Cycle-by-cycle monitor: strobe timing, values and moving-average model.
  always @(negedge clk) begin : mon
    logic [N_CH-1:0] emv, eto, eav;
    int ev [N_CH];
    int s;
    emv = '0;
    eto = '0;
    eav = '0;
    for (int i = 0; i < N_CH; i++) begin
      ev[i]  = 0;
      eav[i] = (avg_due[i] == cyc);
    end
    for (int i = meas_q.size() - 1; i >= 0; i--) begin
      if (meas_q[i].cyc == cyc) begin
        emv[meas_q[i].ch] = 1'b1;
        ev[meas_q[i].ch]  = meas_q[i].val;
        meas_q.delete(i);
      end
    end
    for (int i = to_q.size() - 1; i >= 0; i--) begin
      if (to_q[i].cyc == cyc) begin
        eto[to_q[i].ch] = 1'b1;
        to_q.delete(i);
      end
    end
    if (avg_valid != '0 || eav != '0) check_val("avg_valid", 32'(avg_valid), 32'(eav));
    for (int i = 0; i < N_CH; i++) begin
      if (eav[i]) begin
        check_val("dist_avg", 32'(dist_avg[i*DW +: DW]), avg_exp[i]);
        check_val("avg_ready", 32'(avg_ready[i]), 32'd1);
        avg_due[i] = -1;
      end
    end
    if (timeout != '0 || eto != '0) check_val("timeout", 32'(timeout), 32'(eto));
    if (meas_valid != '0 || emv != '0) check_val("meas_valid", 32'(meas_valid), 32'(emv));
    for (int i = 0; i < N_CH; i++) begin
      if (emv[i]) begin
        check_val("distance", 32'(distance[i*DW +: DW]), ev[i]);
        if (nsamp[i] < 256) begin
          samples[i][nsamp[i]] = ev[i];
          nsamp[i]++;
        end
        if (nsamp[i] >= DEPTH) begin
          s = 0;
          for (int k = nsamp[i] - DEPTH; k < nsamp[i]; k++) s += samples[i][k];
          avg_exp[i] = s / DEPTH;
          avg_due[i] = cyc + 1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, l1;
    clear_model();
    reset = 1'b1;
    step(3);
    // Reset state
    check_val("rst_distance",   32'(distance),   32'd0);
    check_val("rst_meas_valid", 32'(meas_valid), 32'd0);
    check_val("rst_dist_avg",   32'(dist_avg),   32'd0);
    check_val("rst_avg_valid",  32'(avg_valid),  32'd0);
    check_val("rst_avg_ready",  32'(avg_ready),  32'd0);
    check_val("rst_timeout",    32'(timeout),    32'd0);
    reset = 1'b0;
    step(3);

    // 1: single 57-cycle pulse
    pulse2(57, 0);
    check_val("t1_distance", 32'(distance[DW-1:0]), 32'd5);

    // 2: fill the averaging buffer
    do_reset();
    pulse2(40, 0);
    pulse2(80, 0);
    pulse2(120, 0);
    check_val("t2_ready_pre", 32'(avg_ready[0]), 32'd0);
    check_val("t2_avg_pre",   32'(dist_avg[DW-1:0]), 32'd0);
    pulse2(160, 0);
    check_val("t2_avg4",   32'(dist_avg[DW-1:0]), 32'd10);
    check_val("t2_ready4", 32'(avg_ready[0]), 32'd1);
    pulse2(200, 0);
    check_val("t2_dist5", 32'(distance[DW-1:0]), 32'd20);
    check_val("t2_avg5",  32'(dist_avg[DW-1:0]), 32'd14);

    // 3: timeout, then normal measurement
    pulse2(250, 0);
    check_val("t3_dist_kept", 32'(distance[DW-1:0]), 32'd20);
    check_val("t3_avg_kept",  32'(dist_avg[DW-1:0]), 32'd14);
    pulse2(30, 0);
    check_val("t3_dist", 32'(distance[DW-1:0]), 32'd3);

    // 4: reset in the middle of a pulse
    step(1);
    pw[0] = 1'b1;
    step(30);
    reset = 1'b1;
    clear_model();
    step(3);
    check_val("t4_distance", 32'(distance), 32'd0);
    check_val("t4_dist_avg", 32'(dist_avg), 32'd0);
    check_val("t4_ready",    32'(avg_ready), 32'd0);
    reset = 1'b0;
    step(20);
    pw = '0;
    step(GAP);
    pulse2(70, 0);
    check_val("t4_dist", 32'(distance[DW-1:0]), 32'd7);

    // 5: shared falling edge
    pulse2(90, 30);
    check_val("t5_dist0", 32'(distance[DW-1:0]),  32'd9);
    check_val("t5_dist1", 32'(distance[DW +: DW]), 32'd3);

    // 6: short pulse and glitch
    pulse2(5, 0);
    check_val("t6_dist5", 32'(distance[DW-1:0]), 32'd0);
    pulse2(1, 0);
    pulse2(25, 0);
    check_val("t6_after_glitch", 32'(distance[DW-1:0]), 32'd2);

    // Random pulse pairs
    for (int r = 0; r < 16; r++) begin
      l0 = ($urandom_range(0, 5) == 0) ? 230 : int'($urandom_range(0, 160));
      l1 = ($urandom_range(0, 5) == 0) ? 230 : int'($urandom_range(0, 160));
      pulse2(l0, l1);
    end

    step(10);
    check_val("pending_expectations", 32'(meas_q.size() + to_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
